decode_stage: RTL and testbench

- Registered RV32I decode stage. Cracks a 32-bit instruction into all register/function fields.
- Generates the sign-extended immediate for every base instruction format and flags illegal encodings.
- Buffers decoded results in a small FIFO with valid/ready handshakes on both sides.
- Sits between fetch and register-read/execute; replaces the purely combinational field splitter.

---
 rtl/decode_stage.sv | 218 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage : registered RV32I decoder with a valid/ready entry FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decode_stage #(
   parameter int XLEN     = 32,
   parameter int PC_WIDTH = 32,
   parameter int DEPTH    = 2,
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_flush,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [31:0]         i_instruction,
   input  logic [PC_WIDTH-1:0] i_pc,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [PC_WIDTH-1:0] o_pc,
   output logic [6:0]          o_opcode,
   output logic [4:0]          o_rd,
   output logic [2:0]          o_funct3,
   output logic [4:0]          o_rs1,
   output logic [4:0]          o_rs2,
   output logic [6:0]          o_funct7,
   output logic [XLEN-1:0]     o_imm,
   output logic [2:0]          o_fmt,
   output logic                o_illegal,
   output logic [CNT_W-1:0]    o_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
   localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
   localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
   localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
   localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] c_OPC_OP     = 7'b0110011;
   localparam logic [6:0] c_OPC_MISC   = 7'b0001111;
   localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] c_FMT_R    = 3'd0;
   localparam logic [2:0] c_FMT_I    = 3'd1;
   localparam logic [2:0] c_FMT_S    = 3'd2;
   localparam logic [2:0] c_FMT_B    = 3'd3;
   localparam logic [2:0] c_FMT_U    = 3'd4;
   localparam logic [2:0] c_FMT_J    = 3'd5;
   localparam logic [2:0] c_FMT_NONE = 3'd6;

   localparam logic [6:0] c_F7_BASE = 7'b0000000;
   localparam logic [6:0] c_F7_ALT  = 7'b0100000;

   // ---------------------------------------------------------------- decode
   logic [6:0]      w_opc;
   logic [2:0]      w_f3;
   logic [6:0]      w_f7;
   logic [2:0]      w_fmt;
   logic            w_ill;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm;

   assign w_opc = i_instruction[6:0];
   assign w_f3  = i_instruction[14:12];
   assign w_f7  = i_instruction[31:25];

   always_comb begin
      w_fmt = c_FMT_NONE;
      w_ill = 1'b0;
      case (w_opc)
         c_OPC_LUI, c_OPC_AUIPC: w_fmt = c_FMT_U;
         c_OPC_JAL:              w_fmt = c_FMT_J;
         c_OPC_JALR: begin
            w_fmt = c_FMT_I;
            w_ill = (w_f3 != 3'b000);
         end
         c_OPC_BRANCH: begin
            w_fmt = c_FMT_B;
            w_ill = (w_f3 == 3'b010) || (w_f3 == 3'b011);
         end
         c_OPC_LOAD: begin
            w_fmt = c_FMT_I;
            w_ill = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
         end
         c_OPC_STORE: begin
            w_fmt = c_FMT_S;
            w_ill = (w_f3 >= 3'b011);
         end
         c_OPC_OPIMM: begin
            w_fmt = c_FMT_I;
            if (w_f3 == 3'b001)
               w_ill = (w_f7 != c_F7_BASE);
            else if (w_f3 == 3'b101)
               w_ill = (w_f7 != c_F7_BASE) && (w_f7 != c_F7_ALT);
         end
         c_OPC_OP: begin
            w_fmt = c_FMT_R;
            if (w_f7 == c_F7_ALT)
               w_ill = (w_f3 != 3'b000) && (w_f3 != 3'b101);
            else
               w_ill = (w_f7 != c_F7_BASE);
         end
         c_OPC_MISC, c_OPC_SYSTEM: w_fmt = c_FMT_I;
         default: w_ill = 1'b1;
      endcase
      if (w_ill)
         w_fmt = c_FMT_NONE;
   end

   always_comb begin
      w_imm32 = 32'd0;
      case (w_fmt)
         c_FMT_I: w_imm32 = {{20{i_instruction[31]}}, i_instruction[31:20]};
         c_FMT_S: w_imm32 = {{20{i_instruction[31]}}, i_instruction[31:25],
                             i_instruction[11:7]};
         c_FMT_B: w_imm32 = {{19{i_instruction[31]}}, i_instruction[31],
                             i_instruction[7], i_instruction[30:25],
                             i_instruction[11:8], 1'b0};
         c_FMT_U: w_imm32 = {i_instruction[31:12], 12'd0};
         c_FMT_J: w_imm32 = {{11{i_instruction[31]}}, i_instruction[31],
                             i_instruction[19:12], i_instruction[20],
                             i_instruction[30:21], 1'b0};
         default: w_imm32 = 32'd0;
      endcase
   end

   // Sign-extend the 32-bit immediate to the full datapath width.
   always_comb begin
      w_imm       = {XLEN{w_imm32[31]}};
      w_imm[31:0] = w_imm32;
   end

   // ------------------------------------------------------------ entry FIFO
   logic [PC_WIDTH-1:0] mem_pc_q  [DEPTH];
   logic [31:0]         mem_ins_q [DEPTH];
   logic [XLEN-1:0]     mem_imm_q [DEPTH];
   logic [2:0]          mem_fmt_q [DEPTH];
   logic                mem_ill_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             w_clear;
   logic             w_ready;
   logic             w_valid;
   logic             w_push;
   logic             w_pop;

   assign w_clear = i_rst || i_flush;
   assign w_ready = (count_q < CNT_W'(DEPTH));
   assign w_valid = (count_q != '0);
   assign w_push  = i_valid && w_ready;
   assign w_pop   = w_valid && i_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_push)
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (w_pop)
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      if (w_push && !w_pop)
         count_d = count_q + CNT_W'(1);
      else if (w_pop && !w_push)
         count_d = count_q - CNT_W'(1);
      // Clearing wins over any same-cycle push or pop.
      if (w_clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
   end

   always_ff @(posedge i_clk) begin
      if (w_push && !w_clear) begin
         mem_pc_q[wr_ptr_q]  <= i_pc;
         mem_ins_q[wr_ptr_q] <= i_instruction;
         mem_imm_q[wr_ptr_q] <= w_imm;
         mem_fmt_q[wr_ptr_q] <= w_fmt;
         mem_ill_q[wr_ptr_q] <= w_ill;
      end
   end

   // --------------------------------------------------------------- outputs
   logic [31:0] w_head_ins;

   assign w_head_ins = w_valid ? mem_ins_q[rd_ptr_q] : 32'd0;

   assign o_ready   = w_ready;
   assign o_valid   = w_valid;
   assign o_count   = count_q;
   assign o_pc      = w_valid ? mem_pc_q[rd_ptr_q]  : '0;
   assign o_imm     = w_valid ? mem_imm_q[rd_ptr_q] : '0;
   assign o_fmt     = w_valid ? mem_fmt_q[rd_ptr_q] : 3'd0;
   assign o_illegal = w_valid ? mem_ill_q[rd_ptr_q] : 1'b0;
   assign o_opcode  = w_head_ins[6:0];
   assign o_rd      = w_head_ins[11:7];
   assign o_funct3  = w_head_ins[14:12];
   assign o_rs1     = w_head_ins[19:15];
   assign o_rs2     = w_head_ins[24:20];
   assign o_funct7  = w_head_ins[31:25];

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage : directed + random bench for decode_stage against a queue model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_decode_stage;

   localparam int XLEN     = 32;
   localparam int PC_WIDTH = 32;
   localparam int DEPTH    = 2;
   localparam int CNT_W    = $clog2(DEPTH + 1);

   logic                clk = 1'b0;
   logic                rst, flush, in_valid, out_ready;
   logic [31:0]         instr;
   logic [PC_WIDTH-1:0] pc;
   logic                o_ready, o_valid, o_illegal;
   logic [PC_WIDTH-1:0] o_pc;
   logic [6:0]          o_opcode, o_funct7;
   logic [4:0]          o_rd, o_rs1, o_rs2;
   logic [2:0]          o_funct3, o_fmt;
   logic [XLEN-1:0]     o_imm;
   logic [CNT_W-1:0]    o_count;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(XLEN), .PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid),
      .o_ready(o_ready), .i_instruction(instr), .i_pc(pc),
      .o_valid(o_valid), .i_ready(out_ready), .o_pc(o_pc),
      .o_opcode(o_opcode), .o_rd(o_rd), .o_funct3(o_funct3), .o_rs1(o_rs1),
      .o_rs2(o_rs2), .o_funct7(o_funct7), .o_imm(o_imm), .o_fmt(o_fmt),
      .o_illegal(o_illegal), .o_count(o_count)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t mq[$];
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference decode: legality tables and immediates from weighted bit sums.
   function automatic void ref_dec(input logic [31:0] ins, output logic [2:0] fmt,
                                   output logic [31:0] imm, output logic ill);
      int unsigned opc = ins[6:0];
      int unsigned f3  = ins[14:12];
      int unsigned f7  = ins[31:25];
      int          v;
      fmt = 3'd6;
      ill = 1'b0;
      if (opc == 'h37 || opc == 'h17)      fmt = 3'd4;
      else if (opc == 'h6F)                fmt = 3'd5;
      else if (opc == 'h67) begin fmt = 3'd1; ill = (f3 != 0); end
      else if (opc == 'h63) begin fmt = 3'd3; ill = (f3 inside {2, 3}); end
      else if (opc == 'h03) begin fmt = 3'd1; ill = !(f3 inside {0, 1, 2, 4, 5}); end
      else if (opc == 'h23) begin fmt = 3'd2; ill = (f3 > 2); end
      else if (opc == 'h13) begin
         fmt = 3'd1;
         ill = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 inside {0, 32}));
      end
      else if (opc == 'h33) begin
         fmt = 3'd0;
         ill = !((f7 == 0) || (f7 == 32 && f3 inside {0, 5}));
      end
      else if (opc == 'h0F || opc == 'h73) fmt = 3'd1;
      else                                  ill = 1'b1;
      if (ill) fmt = 3'd6;
      v = 0;
      case (fmt)
         3'd1: v = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
         3'd2: v = int'(ins[31:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 4096 : 0);
         3'd3: v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2
                   - (ins[31] ? 4096 : 0);
         3'd4: v = int'(ins[31:12]) * 4096;
         3'd5: v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
                   - (ins[31] ? 1048576 : 0);
         default: v = 0;
      endcase
      imm = 32'(v);
   endfunction

   task automatic check_outputs;
      logic [2:0]  f;
      logic [31:0] im;
      logic        il;
      chk("count", o_count, mq.size());
      chk("ready", o_ready, mq.size() < DEPTH);
      chk("valid", o_valid, mq.size() != 0);
      if (mq.size() == 0) begin
         chk("idle_fields", {o_pc, o_opcode, o_rd, o_funct3, o_rs1, o_rs2, o_funct7}, 64'd0);
         chk("idle_dec", {o_imm, o_fmt, o_illegal}, 64'd0);
      end else begin
         ref_dec(mq[0].ins, f, im, il);
         chk("pc", o_pc, mq[0].pc);
         chk("fields", {o_funct7, o_rs2, o_rs1, o_funct3, o_rd, o_opcode}, mq[0].ins);
         chk("imm", o_imm, im);
         chk("fmt", o_fmt, f);
         chk("illegal", o_illegal, il);
      end
   endtask

   // One clock: check current outputs, drive inputs, advance model at the edge.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic rdy, input logic fl, input logic rs);
      bit push, pop;
      if (chk_en) check_outputs();
      in_valid = v; instr = ins; pc = p; out_ready = rdy; flush = fl; rst = rs;
      @(posedge clk);
      push = v && (mq.size() < DEPTH);
      pop  = rdy && (mq.size() != 0);
      if (rs || fl) mq.delete();
      else begin
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back('{pc: p, ins: ins});
      end
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_ins();
      logic [6:0]  opcs [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00};
      logic [31:0] r = $urandom;
      int          k = $urandom_range(0, 11);
      r[6:0] = (k == 11) ? 7'($urandom) : opcs[k];
      case ($urandom_range(0, 3))
         0: r[31:25] = 7'h00;
         1: r[31:25] = 7'h20;
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      in_valid = 0; instr = 0; pc = 0; out_ready = 0; flush = 0; rst = 1;
      @(negedge clk);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      chk_en = 1'b1;

      // addi x1,x2,-1
      cycle(1, 32'hFFF10093, 32'h100, 1, 0, 0);
      chk("addi_valid", o_valid, 1'b1);
      chk("addi_imm", o_imm, 32'hFFFFFFFF);
      chk("addi_fmt", o_fmt, 3'd1);
      chk("addi_rd_rs1", {o_rd, o_rs1, o_opcode}, {5'd1, 5'd2, 7'b0010011});
      chk("addi_pc", o_pc, 32'h100);
      // beq x1,x2,-4 then lui x5,0x12345
      cycle(1, 32'hFE208EE3, 32'h104, 1, 0, 0);
      chk("beq_imm", o_imm, 32'hFFFFFFFC);
      chk("beq_fmt", o_fmt, 3'd3);
      chk("beq_rs", {o_rs1, o_rs2}, {5'd1, 5'd2});
      cycle(1, 32'h123452B7, 32'h108, 1, 0, 0);
      chk("lui_imm", o_imm, 32'h12345000);
      chk("lui_fmt_rd", {o_fmt, o_rd}, {3'd4, 5'd5});
      cycle(0, 0, 0, 1, 0, 0);

      // Back-pressure: third offer is held until space appears.
      cycle(1, 32'h00500113, 32'h200, 0, 0, 0);
      cycle(1, 32'h00A00193, 32'h204, 0, 0, 0);
      cycle(1, 32'h00308233, 32'h208, 0, 0, 0);
      chk("full_ready", o_ready, 1'b0);
      chk("full_count", o_count, 2);
      cycle(1, 32'h00308233, 32'h208, 1, 0, 0);
      cycle(1, 32'h00308233, 32'h208, 1, 0, 0);
      cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 0, 0);

      // Illegal encodings flow through like any other entry.
      cycle(1, 32'h00000000, 32'h300, 1, 0, 0);
      chk("ill0", {o_illegal, o_fmt}, {1'b1, 3'd6});
      chk("ill0_imm", o_imm, 32'd0);
      cycle(1, 32'h40001033, 32'h304, 1, 0, 0);
      chk("ill_sll", {o_illegal, o_fmt}, {1'b1, 3'd6});
      cycle(0, 0, 0, 1, 0, 0);

      // Flush while full with a concurrent offer.
      cycle(1, 32'h00100093, 32'h400, 0, 0, 0);
      cycle(1, 32'h00200093, 32'h404, 0, 0, 0);
      cycle(1, 32'h00300093, 32'h408, 0, 1, 0);
      chk("flush_state", {o_valid, o_ready, 30'(o_count)}, {1'b0, 1'b1, 30'd0});
      cycle(0, 0, 0, 1, 0, 0);

      // Reset with one pending entry and downstream ready.
      cycle(1, 32'h00400093, 32'h500, 0, 0, 0);
      chk("pre_rst_count", o_count, 1);
      cycle(0, 0, 0, 1, 0, 1);
      chk("rst_state", {o_valid, o_ready, 30'(o_count)}, {1'b0, 1'b1, 30'd0});
      chk("rst_imm", o_imm, 32'd0);
      cycle(0, 0, 0, 1, 0, 0);

      for (int i = 0; i < 600; i++) begin
         cycle(($urandom % 4) != 0, rand_ins(), $urandom, ($urandom % 3) != 0,
               ($urandom % 50) == 0, ($urandom % 80) == 0);
      end
      check_outputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
